mac_seq: RTL and testbench
==========================

# mac_seq

Sequencer that time-shares one signed 8x8 multiply-accumulate unit (26-bit accumulator, synchronous clear) across N_OUT output neurons of a fully connected layer. On a start pulse it walks the weight and input memories for each neuron and feeds operands to the MAC, controlling its clear. It post-processes each finished accumulation with ReLU, shift and saturation and writes one 8-bit result per neuron. It sits between the layer memories and the MAC datapath and is launched by the top-level network controller.

## Interface
- N_IN, 32, products per neuron (>=2)
- N_OUT, 8, neurons per layer (>=1)
- SHIFT, 7, right-shift applied to the accumulator before saturation (0..18)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  launch pulse; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until the final WRITE cycle inclusive
- done  out  1  one-cycle pulse after the last result is written
- w_addr  out  $clog2(N_IN*N_OUT)  weight memory read address = neuron*N_IN + j
- x_addr  out  $clog2(N_IN)  input memory read address = j
- w_rdata  in  8  signed weight; synchronous memory, valid one cycle after address
- x_rdata  in  8  signed input; same latency
- mac_in1, mac_in2  out  8  signed MAC operands
- mac_clr  out  1  MAC clear; accumulator loads 0 at the next edge
- mac_acc  in  26  signed MAC accumulator
- res_we  out  1  result write strobe
- res_addr  out  $clog2(N_OUT)  neuron index
- res_data  out  8  result, range 0..127

## Operation
- States: IDLE, LOAD, MAC, WRITE. Counters: j (0..N_IN-1), neuron (0..N_OUT-1).
- IDLE: mac_clr=1, operands 0, addresses 0. On start -> LOAD, neuron=0.
- LOAD (1 cycle): mac_clr=1, present j=0 address for the current neuron. -> MAC.
- MAC (N_IN cycles): mac_clr=0. mac_in1=w_rdata and mac_in2=x_rdata for element j. Present the address for j+1 when j<N_IN-1. After j=N_IN-1 -> WRITE.
- WRITE (1 cycle): mac_acc holds the complete sum. res_we=1, res_addr=neuron, res_data=f(mac_acc), mac_clr=1, operands 0.
  - If neuron<N_OUT-1: increment neuron, present j=0 address of the next neuron, -> MAC. There is no LOAD gap.
  - Else -> IDLE and pulse done in the next cycle.
- f(acc): acc<0 -> 0. Otherwise s=acc>>>SHIFT; s>127 -> 127; else s[6:0].
- Operands are forced to 0 whenever mac_clr=1, so a stray accumulate is harmless.
- start while busy is ignored.
- start in the done cycle (state IDLE) is accepted as a new launch.
- Reset at any point: state IDLE, counters 0. All registered outputs return to reset values. The MAC is cleared via mac_clr=1.

## Timing
- Reset values: busy=0, done=0, res_we=0, res_addr=0, res_data=0, w_addr=0, x_addr=0, mac_clr=1, mac_in1=mac_in2=0.
- With start sampled at cycle 0:
  - LOAD at cycle 1.
  - Neuron k MAC cycles: 2+k*(N_IN+1) .. 1+k*(N_IN+1)+N_IN.
  - WRITE for neuron k at cycle 2+N_IN+k*(N_IN+1).
  - done at cycle 2+N_OUT*(N_IN+1).
- Throughput is one neuron per N_IN+1 cycles.
- res_we is high exactly one cycle per neuron, N_OUT pulses per launch.
- mac_clr is low for exactly N_IN consecutive cycles per neuron.

## Test plan
- N_IN=4, N_OUT=2, SHIFT=2. All weights 1, inputs 10 -> res_data=10 at res_addr 0 (cycle 6) and res_addr 1 (cycle 11); done at cycle 12.
- Neuron 0 weights -1, inputs 10 (acc=-40) -> res_data 0 (ReLU). Neuron 1 weights 3, inputs 5 (acc=60) -> res_data 15.
- Saturation with SHIFT=2: all operands -128 (acc=65536) -> 127. Weights 127 and inputs 127 -> 127. Acc=511 (e.g. products 127,127,127,130) -> 127. Acc=508 -> 127.
- Assert start at cycles 3 and 8 during a run -> ignored, with exactly 2 res_we pulses. A start coincident with the done cycle launches a new run whose LOAD is at done+1.
- Assert rst_n low at cycle 7 mid-neuron 1 -> all outputs at reset values immediately. A new start after release -> full correct run with fresh accumulation, no residue from the aborted neuron.
- N_IN=2, N_OUT=1 minimum config -> WRITE at cycle 4, done at cycle 5, correct result.

Source files
------------

// File: rtl/mac_seq.sv
// mac_seq: sequences one shared signed 8x8 MAC across N_OUT neurons of a
// fully connected layer. Each neuron gets N_IN back-to-back MAC cycles
// followed by one WRITE cycle. WRITE applies ReLU, a right shift and
// saturation to the accumulator and writes one 8-bit result.
module mac_seq #(
  parameter int N_IN  = 32,
  parameter int N_OUT = 8,
  parameter int SHIFT = 7,
  localparam int WA_W = $clog2(N_IN * N_OUT),
  localparam int XA_W = $clog2(N_IN),
  localparam int RA_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [WA_W-1:0]        w_addr_o,
  output logic [XA_W-1:0]        x_addr_o,
  input  logic signed [7:0]      w_rdata_i,
  input  logic signed [7:0]      x_rdata_i,
  output logic signed [7:0]      mac_in1_o,
  output logic signed [7:0]      mac_in2_o,
  output logic                   mac_clr_o,
  input  logic signed [25:0]     mac_acc_i,
  output logic                   res_we_o,
  output logic [RA_W-1:0]        res_addr_o,
  output logic [7:0]             res_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_WRITE} state_t;

  localparam logic [XA_W-1:0] J_LAST = XA_W'(N_IN - 1);
  localparam logic [RA_W-1:0] N_LAST = RA_W'(N_OUT - 1);

  state_t            state_q, state_d;
  logic [XA_W-1:0]   j_q, j_d;
  logic [RA_W-1:0]   n_q, n_d;
  logic              done_q, done_d;

  // Weight row base for the current neuron, kept 32 bits wide and
  // truncated only where it drives the address port.
  logic [31:0]       base_cur;
  logic signed [25:0] acc_shifted;
  logic [7:0]        res_val;

  assign base_cur    = 32'(n_q) * 32'(N_IN);
  assign acc_shifted = mac_acc_i >>> SHIFT;
  assign done_o      = done_q;

  // Post-processing: ReLU, arithmetic shift, saturate to 0..127.
  always_comb begin
    res_val = 8'd0;
    if (mac_acc_i[25]) begin
      res_val = 8'd0;
    end else if (acc_shifted > 26'sd127) begin
      res_val = 8'd127;
    end else begin
      res_val = {1'b0, acc_shifted[6:0]};
    end
  end

  // State, counters and done pulse; reset returns everything to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      n_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      n_q     <= n_d;
      done_q  <= done_d;
    end
  end

  // Next-state and outputs. The operands are zero whenever mac_clr is high.
  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    n_d        = n_q;
    done_d     = 1'b0;
    busy_o     = 1'b0;
    mac_clr_o  = 1'b1;
    mac_in1_o  = 8'sd0;
    mac_in2_o  = 8'sd0;
    w_addr_o   = '0;
    x_addr_o   = '0;
    res_we_o   = 1'b0;
    res_addr_o = '0;
    res_data_o = 8'd0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          n_d     = '0;
          j_d     = '0;
        end
      end
      S_LOAD: begin
        busy_o   = 1'b1;
        w_addr_o = WA_W'(base_cur);
        x_addr_o = '0;
        j_d      = '0;
        state_d  = S_MAC;
      end
      S_MAC: begin
        busy_o    = 1'b1;
        mac_clr_o = 1'b0;
        mac_in1_o = w_rdata_i;
        mac_in2_o = x_rdata_i;
        if (j_q != J_LAST) begin
          // Prefetch element j+1 so it arrives exactly one cycle later.
          w_addr_o = WA_W'(base_cur + 32'(j_q) + 32'd1);
          x_addr_o = j_q + 1'b1;
          j_d      = j_q + 1'b1;
        end else begin
          j_d     = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        busy_o     = 1'b1;
        res_we_o   = 1'b1;
        res_addr_o = n_q;
        res_data_o = res_val;
        if (n_q != N_LAST) begin
          // Fetch element 0 of the next neuron now, so MAC follows without a gap.
          n_d      = n_q + 1'b1;
          w_addr_o = WA_W'(base_cur + 32'(N_IN));
          x_addr_o = '0;
          state_d  = S_MAC;
        end else begin
          n_d     = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: two instances (N_IN=4/N_OUT=2/SHIFT=2 and
// N_IN=2/N_OUT=1/SHIFT=7) with behavioural memories and MAC. Expected writes
// and done cycles are queued at launch and checked by per-instance monitors.
module tb_mac_seq;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A: N_IN=4, N_OUT=2, SHIFT=2 ----------------
  logic              start_a = 1'b0;
  logic              busy_a, done_a, clr_a, we_a;
  logic [2:0]        wa_a;
  logic [1:0]        xa_a;
  logic signed [7:0] wr_a, xr_a, in1_a, in2_a;
  logic signed [25:0] acc_a = '0;
  logic [0:0]        ra_a;
  logic [7:0]        rd_a;
  logic signed [7:0] wmem_a [8];
  logic signed [7:0] xmem_a [4];
  exp_t              qa [$];
  int                dqa [$];
  exp_t              ea;

  mac_seq #(.N_IN(4), .N_OUT(2), .SHIFT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .w_addr_o(wa_a), .x_addr_o(xa_a), .w_rdata_i(wr_a), .x_rdata_i(xr_a),
    .mac_in1_o(in1_a), .mac_in2_o(in2_a), .mac_clr_o(clr_a), .mac_acc_i(acc_a),
    .res_we_o(we_a), .res_addr_o(ra_a), .res_data_o(rd_a)
  );

  always @(posedge clk) begin
    wr_a <= wmem_a[wa_a];
    xr_a <= xmem_a[xa_a];
    if (clr_a) acc_a <= '0;
    else       acc_a <= acc_a + 26'(in1_a) * 26'(in2_a);
  end

  // ---------------- instance B: N_IN=2, N_OUT=1, SHIFT=7 ----------------
  logic              start_b = 1'b0;
  logic              busy_b, done_b, clr_b, we_b;
  logic [0:0]        wa_b, xa_b, ra_b;
  logic signed [7:0] wr_b, xr_b, in1_b, in2_b;
  logic signed [25:0] acc_b = '0;
  logic [7:0]        rd_b;
  logic signed [7:0] wmem_b [2];
  logic signed [7:0] xmem_b [2];
  exp_t              qb [$];
  int                dqb [$];
  exp_t              eb;

  mac_seq #(.N_IN(2), .N_OUT(1), .SHIFT(7)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .w_addr_o(wa_b), .x_addr_o(xa_b), .w_rdata_i(wr_b), .x_rdata_i(xr_b),
    .mac_in1_o(in1_b), .mac_in2_o(in2_b), .mac_clr_o(clr_b), .mac_acc_i(acc_b),
    .res_we_o(we_b), .res_addr_o(ra_b), .res_data_o(rd_b)
  );

  always @(posedge clk) begin
    wr_b <= wmem_b[wa_b];
    xr_b <= xmem_b[xa_b];
    if (clr_b) acc_b <= '0;
    else       acc_b <= acc_b + 26'(in1_b) * 26'(in2_b);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor A: pop expected writes / done pulses as the DUT presents them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we_a) begin
        $display("A write addr=%0d data=%0d cyc=%0d", ra_a, rd_a, cyc);
        if (qa.size() == 0) begin
          chk("a_unexpected_we", 32'd1, 32'd0);
        end else begin
          ea = qa.pop_front();
          chk("a_res_addr", 32'(ra_a), ea.addr);
          chk("a_res_data", 32'(rd_a), ea.data);
          chk("a_we_cycle", cyc, ea.cyc);
          chk("a_busy_in_write", 32'(busy_a), 32'd1);
        end
      end
      if (done_a) begin
        $display("A done cyc=%0d", cyc);
        if (dqa.size() == 0) begin
          chk("a_unexpected_done", 32'd1, 32'd0);
        end else begin
          chk("a_done_cycle", cyc, dqa.pop_front());
          chk("a_busy_at_done", 32'(busy_a), 32'd0);
        end
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we_b) begin
        $display("B write addr=%0d data=%0d cyc=%0d", ra_b, rd_b, cyc);
        if (qb.size() == 0) begin
          chk("b_unexpected_we", 32'd1, 32'd0);
        end else begin
          eb = qb.pop_front();
          chk("b_res_addr", 32'(ra_b), eb.addr);
          chk("b_res_data", 32'(rd_b), eb.data);
          chk("b_we_cycle", cyc, eb.cyc);
        end
      end
      if (done_b) begin
        $display("B done cyc=%0d", cyc);
        if (dqb.size() == 0) chk("b_unexpected_done", 32'd1, 32'd0);
        else                 chk("b_done_cycle", cyc, dqb.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic fill_wa(input int n, input int w0, input int w1, input int w2, input int w3);
    wmem_a[n*4+0] = 8'(w0); wmem_a[n*4+1] = 8'(w1);
    wmem_a[n*4+2] = 8'(w2); wmem_a[n*4+3] = 8'(w3);
  endtask

  task automatic fill_xa(input int x0, input int x1, input int x2, input int x3);
    xmem_a[0] = 8'(x0); xmem_a[1] = 8'(x1); xmem_a[2] = 8'(x2); xmem_a[3] = 8'(x3);
  endtask

  // Writes for neuron k at c+2+N_IN+k*(N_IN+1); done at c+2+N_OUT*(N_IN+1).
  task automatic push_a(input int c, input int e0, input int e1);
    qa.push_back('{0, e0, c + 6});
    qa.push_back('{1, e1, c + 11});
    dqa.push_back(c + 12);
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic launch_a(output int c);
    @(negedge clk);
    c = cyc;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("a_busy_in_load", 32'(busy_a), 32'd1);
    chk("a_clr_in_load", 32'(clr_a), 32'd1);
    @(negedge clk);
    chk("a_clr_in_mac", 32'(clr_a), 32'd0);
  endtask

  task automatic launch_b(output int c);
    @(negedge clk);
    c = cyc;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 200 && (qa.size() + dqa.size() + qb.size() + dqb.size()) != 0; i++)
      @(negedge clk);
    chk("drain_pending", 32'(qa.size() + dqa.size() + qb.size() + dqb.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_a();
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_res_we", 32'(we_a), 32'd0);
    chk("rst_res_addr", 32'(ra_a), 32'd0);
    chk("rst_res_data", 32'(rd_a), 32'd0);
    chk("rst_w_addr", 32'(wa_a), 32'd0);
    chk("rst_x_addr", 32'(xa_a), 32'd0);
    chk("rst_mac_clr", 32'(clr_a), 32'd1);
    chk("rst_mac_in1", 32'(in1_a), 32'd0);
    chk("rst_mac_in2", 32'(in2_a), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    for (int i = 0; i < 8; i++) wmem_a[i] = 8'sd0;
    for (int i = 0; i < 4; i++) xmem_a[i] = 8'sd0;
    for (int i = 0; i < 2; i++) begin wmem_b[i] = 8'sd0; xmem_b[i] = 8'sd0; end
    #2;
    check_reset_a();
    chk("rst_b_busy", 32'(busy_b), 32'd0);
    chk("rst_b_mac_clr", 32'(clr_b), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic: weights 1, inputs 10 -> acc 40 >> 2 = 10 for both neurons.
    fill_wa(0, 1, 1, 1, 1); fill_wa(1, 1, 1, 1, 1); fill_xa(10, 10, 10, 10);
    launch_a(c); push_a(c, 10, 10); drain();

    // ReLU: -40 -> 0; neuron 1 acc 60 -> 15.
    fill_wa(0, -1, -1, -1, -1); fill_wa(1, 3, 3, 0, 0);
    launch_a(c); push_a(c, 0, 15); drain();

    // Saturation: all -128 -> acc 65536 -> 127.
    fill_wa(0, -128, -128, -128, -128); fill_wa(1, -128, -128, -128, -128);
    fill_xa(-128, -128, -128, -128);
    launch_a(c); push_a(c, 127, 127); drain();

    // 127*127 products -> 127; neuron 1 acc 381+130 = 511 -> 127.
    fill_wa(0, 127, 127, 127, 127); fill_wa(1, 1, 1, 1, 65); fill_xa(127, 127, 127, 2);
    launch_a(c); push_a(c, 127, 127); drain();

    // Acc 508 -> 127 exactly; neuron 1 acc 380 -> 95.
    fill_wa(0, 1, 1, 1, 127); fill_wa(1, 1, 1, 1, -1); fill_xa(127, 127, 127, 1);
    launch_a(c); push_a(c, 127, 95); drain();

    // Start while busy ignored; start in done cycle relaunches (LOAD at done+1).
    fill_wa(0, 1, 1, 1, 1); fill_wa(1, 1, 1, 1, 1); fill_xa(10, 10, 10, 10);
    launch_a(c); push_a(c, 10, 10);
    at_cyc(c + 3); start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    at_cyc(c + 8); start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    at_cyc(c + 12); start_a = 1'b1; push_a(c + 12, 10, 10);
    @(negedge clk); start_a = 1'b0;
    drain();

    // Reset mid-neuron 1: neuron 0 (acc 2000 -> 127) writes, then abort.
    fill_wa(0, 50, 50, 50, 50); fill_wa(1, 50, 50, 50, 50);
    launch_a(c);
    qa.push_back('{0, 127, c + 6});
    at_cyc(c + 7);
    rst_n = 1'b0;
    #1;
    check_reset_a();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("a_aborted_queue_empty", 32'(qa.size() + dqa.size()), 32'd0);
    // Fresh run after the abort: 3*10*4 = 120 -> 30, no residue.
    fill_wa(0, 3, 3, 3, 3); fill_wa(1, 2, 2, 2, 2);
    launch_a(c); push_a(c, 30, 20); drain();

    // Minimum config, SHIFT=7: 10000+5000 = 15000 -> 117; WRITE c+4, done c+5.
    wmem_b[0] = 8'sd100; wmem_b[1] = 8'sd100; xmem_b[0] = 8'sd100; xmem_b[1] = 8'sd50;
    launch_b(c); qb.push_back('{0, 117, c + 4}); dqb.push_back(c + 5); drain();
    // 2*127*127 = 32258 -> 252 -> 127.
    wmem_b[0] = 8'sd127; wmem_b[1] = 8'sd127; xmem_b[0] = 8'sd127; xmem_b[1] = 8'sd127;
    launch_b(c); qb.push_back('{0, 127, c + 4}); dqb.push_back(c + 5); drain();
    // -10000+5000 -> ReLU 0.
    wmem_b[0] = -8'sd100; wmem_b[1] = 8'sd100; xmem_b[0] = 8'sd100; xmem_b[1] = 8'sd50;
    launch_b(c); qb.push_back('{0, 0, c + 4}); dqb.push_back(c + 5); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
